i2c_master_multi: RTL and testbench
===================================

Name: i2c_master_multi

Overview:
- Second-generation I2C master for the i2c block family.
- Issues START, then a 7-bit address plus R/W bit, then a run-time byte count of data bytes, then STOP.
- Checks every ACK slot and signals a NACK error; bus speed is set by a prescale parameter.
- Sits between a local byte-stream producer/consumer and the open-drain pad logic; sda_out/scl of 1 means release the line.

Parameters:
- CLK_DIV, 8: clk cycles per SCL quarter-bit (one bit = 4*CLK_DIV clk); legal range 2..255.
- CNT_W, 4: width of byte-count input; a transaction carries at most 2^CNT_W-1 bytes.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  request transaction; sampled only in IDLE
- rw  in  1  1 = read, 0 = write; captured with start
- addr  in  7  slave address; captured with start
- nbytes  in  CNT_W  data byte count; captured with start; 0 = address-only probe
- tx_data  in  8  next write byte
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  one-cycle pulse: tx_data consumed
- rx_data  out  8  last received byte
- rx_valid  out  1  one-cycle pulse: rx_data updated
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse after STOP completes
- nack_err  out  1  sticky; set on slave NACK; cleared by the next accepted start
- state  out  4  current FSM state, for debug
- scl  out  1  serial clock
- sda_out  out  1  serial data drive
- sda_in  in  1  serial data sense

Behaviour:
- Reset values (asserted immediately on rst low): scl=1, sda_out=1, busy=0, done=0, tx_ready=0, rx_valid=0, nack_err=0, rx_data=0, state=IDLE, counters=0.
- Reset mid-transfer: the bus is released the same cycle. No STOP is generated.
- Bit timing uses quarter phases Q0..Q3, each CLK_DIV clk long:
  - Q0: scl=0, sda_out updated at Q0 entry.
  - Q1 and Q2: scl=1.
  - Q3: scl=0.
  - sda_in is sampled on the first clk of Q2.
- State encodings: IDLE=0, START=1, ADDR=2, ADDR_ACK=3, WRITE=4, WRITE_ACK=5, READ=6, READ_ACK=7, STOP=8, DONE=9.
- IDLE: scl=1, sda_out=1.
  - start=1 captures rw, addr and nbytes, sets busy, clears nack_err, then goes to START.
  - start while busy is ignored.
- START (one bit-time):
  - Q0: sda=1, scl=1.
  - Q1–Q2: sda=0, scl=1.
  - Q3: sda=0, scl=0.
- ADDR: 8 bits MSB first; byte = {addr, rw}.
- ADDR_ACK: sda_out=1 for the ACK bit-time.
  - sampled 1: set nack_err, go to STOP.
  - sampled 0 and nbytes=0: go to STOP.
  - sampled 0, otherwise: go to WRITE if rw=0, READ if rw=1.
- WRITE: at Q0 of bit 7, if tx_valid=1, latch tx_data, pulse tx_ready and shift out MSB first.
  - If tx_valid=0 at that point, hold scl=0 and sda unchanged and stall the phase counter until tx_valid=1.
- WRITE_ACK: sda_out=1.
  - sampled 1: set nack_err, go to STOP.
  - sampled 0: decrement the remaining count; 0 goes to STOP, else back to WRITE.
- READ: sda_out=1 for 8 bits; shift in sda_in MSB first.
  - After bit 0, update rx_data and pulse rx_valid.
- READ_ACK: master drives sda_out=0 (ACK) if bytes remain after this one, else 1 (NACK).
  - Go to READ or STOP accordingly.
- STOP (one bit-time):
  - Q0: sda=0, scl=0.
  - Q1: sda=0, scl=1.
  - Q2–Q3: sda=1, scl=1.
- DONE: pulse done for 1 clk, clear busy, go to IDLE. A new start is accepted on the next cycle.
- Latency with no stalls: (11 + 9*nbytes) * 4*CLK_DIV clk from start accept to done.
- The byte counter and phase counter never wrap within a transaction.

Optional Feature:
- I2C_CLK_STRETCH_EN.
- Defined:
  - Adds input port scl_in (1 bit).
  - At each Q0→Q1 transition the FSM and phase counter hold, with scl=1 driven, until scl_in=1, so a slave may stretch the clock.
  - Q1 duration counts from the cycle scl_in is first seen high.
- Undefined:
  - No scl_in port.
  - Timing is purely counter-based.

Test Plan:
- Write 2 bytes 0x12, 0x34 to addr 0x5A, slave ACKs all, CLK_DIV=4 -> SDA bytes 0xB4, 0x12, 0x34; tx_ready pulses twice; done after 29*16 clk; nack_err=0.
- Read 3 bytes from addr 0x5A, slave drives 0xA5, 0x3C, 0xFF -> address byte 0xB5; rx_valid three times with those values; master ACK, ACK, NACK; STOP; done.
- Addr 0x21 with no slave (sda_in=1 in ACK slot) -> nack_err=1; no data bytes; STOP follows directly; done; nack_err clears on next start.
- Write with tx_valid held low 50 clk before byte 2 -> scl stays 0 for the stall; transfer resumes intact; bytes correct.
- nbytes=0 probe, slave ACKs -> START, 0xB4, ACK, STOP; done; no tx_ready or rx_valid.
- rst low during bit 3 of a data byte -> scl=1 and sda_out=1 in the same cycle; busy=0; state=0; a new start after rst high completes normally.

Source files
------------

// File: rtl/i2c_master_multi.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_master_multi
//  Purpose  : I2C master. Issues START, a 7-bit address plus R/W bit, a
//             run-time count of data bytes and then STOP. Every ACK slot is
//             checked and a slave NACK sets a sticky error flag.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk, rst            system clock, asynchronous active-low reset
//    start, rw, addr,    transaction request and its parameters; captured
//    nbytes              when start is seen in IDLE (nbytes=0 is a probe)
//    tx_data, tx_valid   write byte stream from the local producer
//    tx_ready            one-cycle pulse when tx_data has been consumed
//    rx_data, rx_valid   last received byte, one-cycle update pulse
//    busy, done          transaction in flight / one-cycle completion pulse
//    nack_err            sticky slave-NACK flag, cleared by the next start
//    state               current FSM state (debug)
//    scl, sda_out        open-drain drives, 1 = release the line
//    sda_in              sensed SDA line
//    scl_in              sensed SCL line (only with I2C_CLK_STRETCH_EN)
//
//  Optional feature macro: I2C_CLK_STRETCH_EN
//    When defined, an scl_in port is added and the first cycle of every Q1
//    quarter is held until scl_in reads high, allowing slave clock
//    stretching. When undefined, bit timing is purely counter based.
//
//  Bit timing: four quarters Q0..Q3, each CLK_DIV clk long. scl is low in
//  Q0/Q3 and high in Q1/Q2; sda_out changes at Q0 entry; sda_in is sampled
//  on the first clk of Q2.
// ============================================================================
module i2c_master_multi #(
    parameter int CLK_DIV = 8,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rw,
    input  logic [6:0]       addr,
    input  logic [CNT_W-1:0] nbytes,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             nack_err,
    output logic [3:0]       state,
    output logic             scl,
    output logic             sda_out,
`ifdef I2C_CLK_STRETCH_EN
    input  logic             scl_in,
`endif
    input  logic             sda_in
);

    localparam int                 DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_START     = 4'd1,
        S_ADDR      = 4'd2,
        S_ADDR_ACK  = 4'd3,
        S_WRITE     = 4'd4,
        S_WRITE_ACK = 4'd5,
        S_READ      = 4'd6,
        S_READ_ACK  = 4'd7,
        S_STOP      = 4'd8,
        S_DONE      = 4'd9
    } state_t;

    state_t           st;
    logic [DIV_W-1:0] div;        // clk count within the current quarter
    logic [1:0]       q;          // quarter index Q0..Q3
    logic [2:0]       bitn;       // bit position within a byte, 7 = MSB
    logic [CNT_W-1:0] cnt;        // data bytes still to transfer
    logic [7:0]       shreg;      // outgoing bits leave from [7], incoming enter at [0]
    logic             rw_r;
    logic             ack_bit;    // sda_in captured in Q2 of the current bit
    logic             need_data;  // WRITE entered without a byte available

    logic quarter_end;
    logic stretch_hold;
    logic data_wait;

    assign quarter_end = (div == DIV_LAST);
    assign data_wait   = (st == S_WRITE) && need_data;
    assign state       = st;

`ifdef I2C_CLK_STRETCH_EN
    // Freeze on the first clk of Q1 until the slave lets SCL rise; that
    // first high cycle then counts as the first clk of Q1.
    assign stretch_hold = (q == 2'd1) && (div == '0) && !scl_in &&
                          (st != S_IDLE) && (st != S_DONE);
`else
    assign stretch_hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= S_IDLE;
            div       <= '0;
            q         <= 2'd0;
            bitn      <= 3'd0;
            cnt       <= '0;
            shreg     <= 8'd0;
            rw_r      <= 1'b0;
            ack_bit   <= 1'b0;
            need_data <= 1'b0;
            scl       <= 1'b1;
            sda_out   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            tx_ready  <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= 8'd0;
            nack_err  <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            case (st)
                S_IDLE: begin
                    scl     <= 1'b1;
                    sda_out <= 1'b1;
                    if (start) begin
                        rw_r     <= rw;
                        shreg    <= {addr, rw};
                        cnt      <= nbytes;
                        busy     <= 1'b1;
                        nack_err <= 1'b0;
                        div      <= '0;
                        q        <= 2'd0;
                        st       <= S_START;
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                    st   <= S_IDLE;
                end
                default: begin
                    if (data_wait) begin
                        // Stalled in Q0 with scl low; the bit starts afresh once loaded.
                        if (tx_valid) begin
                            shreg     <= tx_data;
                            sda_out   <= tx_data[7];
                            tx_ready  <= 1'b1;
                            need_data <= 1'b0;
                        end
                    end else if (!stretch_hold) begin
                        if (q == 2'd2 && div == '0) begin
                            ack_bit <= sda_in;
                            if (st == S_READ)
                                shreg <= {shreg[6:0], sda_in};
                        end
                        if (!quarter_end) begin
                            div <= div + DIV_W'(1);
                        end else begin
                            div <= '0;
                            q   <= q + 2'd1;
                            case (q)
                                2'd0: begin
                                    scl <= 1'b1;
                                    if (st == S_START)
                                        sda_out <= 1'b0;
                                end
                                2'd1: begin
                                    if (st == S_STOP)
                                        sda_out <= 1'b1;
                                end
                                2'd2: begin
                                    if (st != S_STOP)
                                        scl <= 1'b0;
                                end
                                2'd3: begin
                                    // End of bit: choose the next bit and drive its SDA.
                                    scl <= 1'b0;
                                    case (st)
                                        S_START: begin
                                            st      <= S_ADDR;
                                            bitn    <= 3'd7;
                                            sda_out <= shreg[7];
                                        end
                                        S_ADDR, S_WRITE: begin
                                            if (bitn == 3'd0) begin
                                                st      <= (st == S_ADDR) ? S_ADDR_ACK : S_WRITE_ACK;
                                                sda_out <= 1'b1;
                                            end else begin
                                                bitn    <= bitn - 3'd1;
                                                shreg   <= {shreg[6:0], 1'b0};
                                                sda_out <= shreg[6];
                                            end
                                        end
                                        S_ADDR_ACK, S_WRITE_ACK: begin
                                            if (ack_bit) begin
                                                nack_err <= 1'b1;
                                                st       <= S_STOP;
                                                sda_out  <= 1'b0;
                                            end else if ((st == S_ADDR_ACK && cnt == '0) ||
                                                         (st == S_WRITE_ACK && cnt == CNT_W'(1))) begin
                                                cnt     <= (st == S_WRITE_ACK) ? cnt - CNT_W'(1) : cnt;
                                                st      <= S_STOP;
                                                sda_out <= 1'b0;
                                            end else if (st == S_ADDR_ACK && rw_r) begin
                                                st      <= S_READ;
                                                bitn    <= 3'd7;
                                                sda_out <= 1'b1;
                                            end else begin
                                                if (st == S_WRITE_ACK)
                                                    cnt <= cnt - CNT_W'(1);
                                                st   <= S_WRITE;
                                                bitn <= 3'd7;
                                                if (tx_valid) begin
                                                    shreg    <= tx_data;
                                                    sda_out  <= tx_data[7];
                                                    tx_ready <= 1'b1;
                                                end else begin
                                                    need_data <= 1'b1;
                                                end
                                            end
                                        end
                                        S_READ: begin
                                            if (bitn == 3'd0) begin
                                                rx_data  <= shreg;
                                                rx_valid <= 1'b1;
                                                st       <= S_READ_ACK;
                                                // ACK while more bytes are wanted, NACK the last one
                                                sda_out  <= (cnt > CNT_W'(1)) ? 1'b0 : 1'b1;
                                            end else begin
                                                bitn    <= bitn - 3'd1;
                                                sda_out <= 1'b1;
                                            end
                                        end
                                        S_READ_ACK: begin
                                            cnt <= cnt - CNT_W'(1);
                                            if (cnt == CNT_W'(1)) begin
                                                st      <= S_STOP;
                                                sda_out <= 1'b0;
                                            end else begin
                                                st      <= S_READ;
                                                bitn    <= 3'd7;
                                                sda_out <= 1'b1;
                                            end
                                        end
                                        S_STOP: begin
                                            st      <= S_DONE;
                                            done    <= 1'b1;
                                            scl     <= 1'b1;
                                            sda_out <= 1'b1;
                                        end
                                        default: begin
                                            st      <= S_IDLE;
                                            busy    <= 1'b0;
                                            scl     <= 1'b1;
                                            sda_out <= 1'b1;
                                        end
                                    endcase
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_master_multi
//  Purpose  : Self-checking bench for i2c_master_multi. A protocol-level
//             slave decodes START/STOP and bytes from the bus, ACKs its
//             address, and serves read data; expected bus traffic, ACK
//             bits, handshakes and latency come from a transaction model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master_multi;

    localparam int CLK_DIV = 4;
    localparam int CNT_W   = 4;
    localparam int BIT_CLK = 4 * CLK_DIV;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             rw;
    logic [6:0]       addr;
    logic [CNT_W-1:0] nbytes;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             busy;
    logic             done;
    logic             nack_err;
    logic [3:0]       state;
    logic             scl;
    logic             sda_out;
    wire              sda_line;

    logic             slave_drive = 1'b1;
    logic             slave_present;
    logic [6:0]       slave_addr;
    logic [7:0]       wdata   [17];
    logic [7:0]       rd_data [17];

    int n_checks = 0;
    int n_fail   = 0;

    assign sda_line = sda_out & slave_drive;

    always #5 clk = ~clk;

    i2c_master_multi #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rw       (rw),
        .addr     (addr),
        .nbytes   (nbytes),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .done     (done),
        .nack_err (nack_err),
        .state    (state),
        .scl      (scl),
        .sda_out  (sda_out),
        .sda_in   (sda_line)
    );

    // ---------------- protocol-level slave and bus monitor ----------------
    logic [7:0] bus_bytes[$];
    logic       bus_acks[$];
    int         n_starts = 0;
    int         n_stops  = 0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         bit_idx  = 0;
    int         byte_idx = 0;
    logic [7:0] cur      = 8'd0;
    logic       sel      = 1'b0;
    logic       rd_mode  = 1'b0;
    logic       rd_done  = 1'b0;

    always @(scl or sda_line) begin
        if (scl && prev_scl && prev_sda && !sda_line) begin
            bus_bytes.delete();
            bus_acks.delete();
            bit_idx = 0; byte_idx = 0; cur = 8'd0;
            sel = 1'b0; rd_mode = 1'b0; rd_done = 1'b0;
            slave_drive = 1'b1;
            n_starts++;
        end else if (scl && prev_scl && !prev_sda && sda_line) begin
            n_stops++;
            sel = 1'b0;
            slave_drive = 1'b1;
        end else if (scl && !prev_scl) begin
            if (bit_idx < 8) begin
                cur = {cur[6:0], sda_line};
                bit_idx++;
                if (bit_idx == 8 && byte_idx == 0) begin
                    sel     = slave_present && (cur[7:1] == slave_addr);
                    rd_mode = cur[0];
                end
            end else begin
                bus_bytes.push_back(cur);
                bus_acks.push_back(sda_line);
                if (rd_mode && byte_idx > 0 && sda_line) rd_done = 1'b1;
                bit_idx = 0;
                byte_idx++;
            end
        end else if (!scl && prev_scl) begin
            slave_drive = 1'b1;
            if (sel) begin
                if (bit_idx == 8 && (byte_idx == 0 || !rd_mode))
                    slave_drive = 1'b0;
                else if (bit_idx < 8 && rd_mode && byte_idx > 0 && !rd_done)
                    slave_drive = rd_data[byte_idx-1][7-bit_idx];
            end
        end
        prev_scl = scl;
        prev_sda = sda_line;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction. reset_at > 0 pulls rst low at that cycle after accept.
    task automatic run_txn(input logic [6:0] a, input logic r, input int n,
                           input bit present, input bit do_stall, input int reset_at);
        logic [7:0] exp_bytes[$];
        logic       exp_acks[$];
        logic [7:0] rx_seen[$];
        int  exp_lat, exp_txr, exp_rx;
        int  cyc, k, n_txr, starts0, stops0, stall_left;
        bit  got_done, scl_hi, stall_started;
        logic [3:0] prev_st;

        // transaction model
        exp_bytes.push_back({a, r});
        exp_acks.push_back(!present);
        if (present) begin
            for (int i = 0; i < n; i++) begin
                exp_bytes.push_back(r ? rd_data[i] : wdata[i]);
                exp_acks.push_back(r ? 1'(i == n - 1) : 1'b0);
            end
        end
        exp_lat = (present ? (11 + 9 * n) : 11) * BIT_CLK + (do_stall ? 51 : 0);
        exp_txr = (present && !r) ? n : 0;
        exp_rx  = (present && r) ? n : 0;

        slave_addr    = a;
        slave_present = present;
        starts0 = n_starts;
        stops0  = n_stops;
        k = 0; n_txr = 0; stall_left = 0;
        got_done = 0; scl_hi = 0; stall_started = 0;
        tx_data  = wdata[0];
        tx_valid = 1'b1;
        addr     = a;
        rw       = r;
        nbytes   = CNT_W'(n);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_on", 32'(busy), 32'd1);
        check("nack_clr", 32'(nack_err), 32'd0);
        prev_st = state;
        cyc = 0;
        while (!got_done && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            if (reset_at > 0 && cyc == reset_at) begin
                rst = 1'b0;
                #1;
                check("rst_scl", 32'(scl), 32'd1);
                check("rst_sda", 32'(sda_out), 32'd1);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_state", 32'(state), 32'd0);
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b1;
                tx_valid = 1'b0;
                return;
            end
            if (tx_ready) begin
                n_txr++;
                k++;
                tx_data = wdata[k];
                if (do_stall && k == 1) tx_valid = 1'b0;
            end
            if (rx_valid) rx_seen.push_back(rx_data);
            if (do_stall) begin
                if (stall_left > 0) begin
                    if (scl) scl_hi = 1;
                    stall_left--;
                    if (stall_left == 0) tx_valid = 1'b1;
                end else if (!stall_started && prev_st == 4'd5 && state == 4'd4 && !tx_valid) begin
                    stall_left    = 50;
                    stall_started = 1;
                end
            end
            prev_st = state;
            if (done) got_done = 1;
        end
        check("done_seen", 32'(got_done), 32'd1);
        check("latency", 32'(cyc), 32'(exp_lat));
        check("nack_err", 32'(nack_err), 32'(!present));
        check("bus_nbytes", 32'(bus_bytes.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && i < bus_bytes.size(); i++) begin
            check("bus_byte", 32'(bus_bytes[i]), 32'(exp_bytes[i]));
            check("ack_bit", 32'(bus_acks[i]), 32'(exp_acks[i]));
        end
        check("starts", 32'(n_starts - starts0), 32'd1);
        check("stops", 32'(n_stops - stops0), 32'd1);
        check("tx_ready_cnt", 32'(n_txr), 32'(exp_txr));
        check("rx_valid_cnt", 32'(rx_seen.size()), 32'(exp_rx));
        for (int i = 0; i < exp_rx && i < rx_seen.size(); i++)
            check("rx_data", 32'(rx_seen[i]), 32'(rd_data[i]));
        if (do_stall) begin
            check("stall_seen", 32'(stall_started), 32'd1);
            check("stall_scl_low", 32'(scl_hi), 32'd0);
        end
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd0);
        check("busy_off", 32'(busy), 32'd0);
        check("idle", 32'(state), 32'd0);
        tx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rw = 1'b0; addr = 7'd0; nbytes = '0;
        tx_data = 8'd0; tx_valid = 1'b0; slave_present = 1'b0; slave_addr = 7'd0;
        for (int i = 0; i < 17; i++) begin
            wdata[i]   = 8'd0;
            rd_data[i] = 8'd0;
        end
        #1 rst = 1'b0;
        #2;
        check("reset_scl", 32'(scl), 32'd1);
        check("reset_sda", 32'(sda_out), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_tx_ready", 32'(tx_ready), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_nack", 32'(nack_err), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // write 0x12, 0x34 to 0x5A
        wdata[0] = 8'h12; wdata[1] = 8'h34;
        run_txn(7'h5A, 1'b0, 2, 1'b1, 1'b0, 0);
        // read 0xA5, 0x3C, 0xFF from 0x5A
        rd_data[0] = 8'hA5; rd_data[1] = 8'h3C; rd_data[2] = 8'hFF;
        run_txn(7'h5A, 1'b1, 3, 1'b1, 1'b0, 0);
        // no slave at 0x21
        run_txn(7'h21, 1'b0, 2, 1'b0, 1'b0, 0);
        // write with producer stall before byte 2 (also clears nack_err)
        wdata[0] = 8'hC3; wdata[1] = 8'h5E;
        run_txn(7'h5A, 1'b0, 2, 1'b1, 1'b1, 0);
        // address-only probe
        run_txn(7'h5A, 1'b0, 0, 1'b1, 1'b0, 0);
        // reset during bit 3 of the first data byte, then a clean transfer
        wdata[0] = 8'h96; wdata[1] = 8'h0F;
        run_txn(7'h5A, 1'b0, 2, 1'b1, 1'b0, 14 * BIT_CLK + 6);
        repeat (2) @(posedge clk);
        #1;
        run_txn(7'h5A, 1'b0, 2, 1'b1, 1'b0, 0);

        // randomized transactions
        for (int t = 0; t < 8; t++) begin
            logic [6:0] ra;
            logic       rr;
            int         rn;
            bit         rp;
            ra = 7'($urandom);
            rr = 1'($urandom);
            rn = int'($urandom_range(0, 5));
            rp = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 17; i++) begin
                wdata[i]   = 8'($urandom);
                rd_data[i] = 8'($urandom);
            end
            run_txn(ra, rr, rn, rp, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
